// File: rtl/parity_serial_tx_if.sv
// Handshake and serial-line bundle between a word source and parity_serial_tx.
interface parity_serial_tx_if #(
    parameter int DATA_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  load;
    logic                  ready;
    logic                  tx_out;
    logic                  parity_out;
    logic                  done;

    modport master (
        output data_in, load,
        input  ready, tx_out, parity_out, done
    );

    modport slave (
        input  data_in, load,
        output ready, tx_out, parity_out, done
    );
endinterface

// File: rtl/parity_serial_tx.sv
// Framed serial transmitter: start, data LSB first, parity, stop.
// Define PARITY_TX_ODD_EN for odd parity; even parity otherwise.
module parity_serial_tx #(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    parity_serial_tx_if.slave bus
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    logic [TW-1:0]         timer;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  tx_q;
    logic                  ready_q;
    logic                  done_q;
    logic                  parity_q;
    logic                  parity_calc;
    logic                  bit_end;

`ifdef PARITY_TX_ODD_EN
    assign parity_calc = ~(^bus.data_in);
`else
    assign parity_calc = ^bus.data_in;
`endif

    assign bit_end    = (timer == TIMER_LAST);
    assign shift_next = shift >> 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        shift    <= bus.data_in;
                        parity_q <= parity_calc;
                        tx_q     <= 1'b0;
                        ready_q  <= 1'b0;
                        timer    <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        timer   <= '0;
                        bit_cnt <= '0;
                        tx_q    <= shift[0];
                        state   <= DATA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        shift <= shift_next;
                        if (bit_cnt == BIT_LAST) begin
                            tx_q  <= parity_q;
                            state <= PARITY;
                        end else begin
                            // Line presents the next bit as the register shifts.
                            bit_cnt <= bit_cnt + CW'(1);
                            tx_q    <= shift_next[0];
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        timer <= '0;
                        tx_q  <= 1'b1;
                        state <= STOP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer   <= '0;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        tx_q    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx_out     = tx_q;
    assign bus.ready      = ready_q;
    assign bus.done       = done_q;
    assign bus.parity_out = parity_q;
endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx: default timing instance plus a 3-clock-per-bit instance.
module tb_parity_serial_tx;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    parity_serial_tx_if #(.DATA_WIDTH(4)) bus_a ();
    parity_serial_tx_if #(.DATA_WIDTH(4)) bus_b ();

    parity_serial_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );
    parity_serial_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(3)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PARITY_TX_ODD_EN
    localparam logic [6:0] SEQ_1011 = 7'b0110101;
    localparam logic [6:0] SEQ_0000 = 7'b0000011;
    localparam logic [6:0] SEQ_1010 = 7'b0010111;
    localparam logic [6:0] SEQ_0110 = 7'b0011011;
    localparam logic       ODD      = 1'b1;
`else
    localparam logic [6:0] SEQ_1011 = 7'b0110111;
    localparam logic [6:0] SEQ_0000 = 7'b0000001;
    localparam logic [6:0] SEQ_1010 = 7'b0010101;
    localparam logic [6:0] SEQ_0110 = 7'b0011001;
    localparam logic       ODD      = 1'b0;
`endif

    logic [6:0] captured;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame on instance A and checks every line cycle; optionally
    // pulses load with 4'hF at sample index inject_at while the frame is busy.
    task automatic frame_a(input string tag, input logic [3:0] d,
                           input logic [6:0] exp_seq, input logic exp_par,
                           input int inject_at);
        bus_a.data_in = d;
        bus_a.load    = 1'b1;
        step();
        bus_a.load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            captured[i] = bus_a.tx_out;
            chk($sformatf("%s_tx%0d", tag, i), bus_a.tx_out, exp_seq[6-i]);
            chk($sformatf("%s_rdy%0d", tag, i), bus_a.ready, 1'b0);
            chk($sformatf("%s_done%0d", tag, i), bus_a.done, 1'b0);
            if (i == inject_at) begin
                bus_a.data_in = 4'hF;
                bus_a.load    = 1'b1;
            end
            step();
            bus_a.load = 1'b0;
        end
        chk({tag, "_done"}, bus_a.done, 1'b1);
        chk({tag, "_ready"}, bus_a.ready, 1'b1);
        chk({tag, "_stop_line"}, bus_a.tx_out, 1'b1);
        chk({tag, "_parity"}, bus_a.parity_out, exp_par);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        captured      = '0;
        reset         = 1'b1;
        bus_a.data_in = '0;
        bus_a.load    = 1'b0;
        bus_b.data_in = '0;
        bus_b.load    = 1'b0;
        #2;
        chk("rst_tx", bus_a.tx_out, 1'b1);
        chk("rst_ready", bus_a.ready, 1'b1);
        chk("rst_done", bus_a.done, 1'b0);
        chk("rst_parity", bus_a.parity_out, 1'b0);
        chk("rst_b_tx", bus_b.tx_out, 1'b1);
        step();
        reset = 1'b0;
        step();

        frame_a("f1011", 4'b1011, SEQ_1011, ~ODD, -1);
        step();
        chk("f1011_done_clear", bus_a.done, 1'b0);
        chk("f1011_idle_line", bus_a.tx_out, 1'b1);

        frame_a("f0000", 4'b0000, SEQ_0000, ODD, -1);
        chk("loopback_clean", ^captured[5:1], ODD);
        chk("loopback_flip", ^(captured[5:1] ^ 5'b00100), ~ODD);
        step();

        frame_a("finj", 4'b1010, SEQ_1010, ODD, 2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("noq_tx%0d", i), bus_a.tx_out, 1'b1);
            chk($sformatf("noq_rdy%0d", i), bus_a.ready, 1'b1);
        end

        bus_a.data_in = 4'b1011;
        bus_a.load    = 1'b1;
        step();
        bus_a.load = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("amid_tx", bus_a.tx_out, 1'b1);
        chk("amid_ready", bus_a.ready, 1'b1);
        chk("amid_done", bus_a.done, 1'b0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("post_rst_done%0d", i), bus_a.done, 1'b0);
        end
        frame_a("f0110", 4'b0110, SEQ_0110, ODD, -1);
        step();

        bus_a.data_in = 4'b0011;
        bus_a.load    = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("b2b_done", bus_a.done, 1'b1);
        chk("b2b_idle_tx", bus_a.tx_out, 1'b1);
        step();
        chk("b2b_restart_tx", bus_a.tx_out, 1'b0);
        chk("b2b_restart_rdy", bus_a.ready, 1'b0);
        bus_a.load = 1'b0;
        for (int i = 0; i < 8; i++) step();

        bus_b.data_in = 4'b0110;
        bus_b.load    = 1'b1;
        step();
        bus_b.load = 1'b0;
        for (int i = 0; i < 21; i++) begin
            chk($sformatf("slow_tx%0d", i), bus_b.tx_out, SEQ_0110[6-(i/3)]);
            chk($sformatf("slow_done%0d", i), bus_b.done, 1'b0);
            step();
        end
        chk("slow_done", bus_b.done, 1'b1);
        chk("slow_ready", bus_b.ready, 1'b1);
        chk("slow_parity", bus_b.parity_out, ODD);
        step();
        chk("slow_done_clear", bus_b.done, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/parity_serial_tx.md
# parity_serial_tx

Serial transmitter for the 4-bit parity-protected link. It accepts a parallel data word, computes its parity bit and shifts out a framed serial stream: start bit, data LSB first, parity, stop. It is the sending end of the link whose receiver compares the recovered data against the recovered parity bit. Even parity is the default: the parity bit equals the XOR of the data bits, so a clean frame makes the receiver's parity result 0.

## Interface
Parameters:
- `DATA_WIDTH`, default 4: data bits per frame; must be ≥ 1.
- `CLKS_PER_BIT`, default 1: clock cycles each serial bit is held; must be ≥ 1.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `data_in`, input, `DATA_WIDTH`: word to send; sampled only on an accepted load.
- `load`, input, 1: send request, accepted only while `ready`=1.
- `ready`, output, 1: idle, can accept a load.
- `tx_out`, output, 1: serial line, idles high.
- `parity_out`, output, 1: parity bit of the last accepted word, held until the next accept.
- `done`, output, 1: one-cycle pulse when a frame's stop bit completes.

## Operation
- States:
  - IDLE: `tx_out`=1, `ready`=1.
  - START: `tx_out`=0.
  - DATA: `tx_out`=shift[0], LSB first.
  - PARITY: `tx_out`=`parity_out`.
  - STOP: `tx_out`=1.
- Accept: `load`=1 and `ready`=1 at a rising edge.
  - On that edge: latch `data_in` into the shift register, set `parity_out` = ^`data_in` (XNOR when odd parity is configured), go to START.
- Bit timer: counts 0..`CLKS_PER_BIT`-1; the state or bit advances when the timer reaches `CLKS_PER_BIT`-1.
- DATA: bit counter runs 0..`DATA_WIDTH`-1; the shift register shifts right once per bit period; PARITY follows the last data bit.
- STOP → IDLE at the end of the stop period; `done`=1 for exactly that one transition cycle.
- `load` while not ready: ignored, no queuing; `data_in` changes mid-frame have no effect.
- `load` held high continuously: a new frame is accepted on the first edge after `ready` rises, giving back-to-back frames separated by one idle cycle.
- Reset values, asynchronous: state IDLE, `tx_out`=1, `ready`=1, `done`=0, `parity_out`=0, counters and shift register 0.
- Reset mid-frame: line returns high at once, the frame is abandoned, no `done` pulse.

## Timing
- Accept edge → `tx_out` falls (start bit) from that edge, registered output.
- Frame length is (`DATA_WIDTH`+3)×`CLKS_PER_BIT` cycles from the accept edge to the `done` edge.
  - Defaults: 7 cycles.
- `ready` is low from the accept edge until the edge that asserts `done`; `ready` and `done` rise on the same edge.
- All outputs come directly from registers; there are no combinational paths from inputs to outputs.

## Configuration
- `PARITY_TX_ODD_EN`:
  - Defined: odd parity, bit = ~(^data). The total count of ones over data plus parity is odd.
  - Undefined (default): even parity, bit = ^data, matching the existing receiver's check.

## Test plan
- Defaults, even parity, load 4'b1011:
  - `tx_out` sequence over 7 cycles is 0,1,1,0,1,1,1.
  - `parity_out`=1.
  - `done` pulses in cycle 7, then `ready`=1.
- Load 4'b0000:
  - `tx_out` is 0,0,0,0,0,0,1; `parity_out`=0.
  - Loopback to the receiver gives parity result 0.
  - Flipping one data bit on the wire gives parity result 1.
- `CLKS_PER_BIT`=3, load 4'b0110:
  - Each bit is held exactly 3 cycles.
  - Frame lasts 21 cycles; `done` on cycle 21.
- Pulse `load` with 4'b1111 during the DATA state: the frame in flight is unchanged and no second frame follows.
- Assert `reset` during the DATA state:
  - `tx_out`=1 and `ready`=1 immediately (asynchronous), no `done`.
  - The next load sends a correct full frame.
- `PARITY_TX_ODD_EN` defined, load 4'b1011: parity bit = 0; load 4'b0000: parity bit = 1.
